// File: rtl/flags_ctrl.sv
// Flags write-port arbiter: merges ALU and microcode flag updates and
// runs the interrupt-entry snapshot / push / clear-TF-IF sequence.
module flags_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [15:0] alu_flags,
    input  logic [8:0]  alu_mask,
    output logic        alu_ready,
    input  logic        uc_valid,
    input  logic [15:0] uc_flags,
    input  logic [8:0]  uc_mask,
    output logic        uc_ready,
    input  logic        int_req,
    output logic        int_ack,
    input  logic [15:0] flags_cur,
    output logic [15:0] saved_flags,
    output logic        saved_valid,
    input  logic        saved_ready,
    output logic [15:0] flags_in,
    output logic [8:0]  update_flags,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        PUSH,
        CLEAR,
        ACK
    } state_t;

    // Only TF and IF are written on interrupt entry.
    localparam logic [8:0] TI_MASK = 9'b0_0110_0000;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  merge_mask;
    logic [15:0] merge_flags;

    // Mask bit k -> architectural flag bit position.
    function automatic logic [3:0] bit_pos(input int k);
        case (k)
            0:       bit_pos = 4'd0;
            1:       bit_pos = 4'd2;
            2:       bit_pos = 4'd4;
            3:       bit_pos = 4'd6;
            4:       bit_pos = 4'd7;
            5:       bit_pos = 4'd8;
            6:       bit_pos = 4'd9;
            7:       bit_pos = 4'd10;
            default: bit_pos = 4'd11;
        endcase
    endfunction

    // Merge both requesters; microcode wins on colliding mask bits.
    always_comb begin
        merge_mask  = (alu_valid ? alu_mask : 9'd0)
                    | (uc_valid ? uc_mask : 9'd0);
        merge_flags = 16'd0;
        for (int k = 0; k < 9; k++) begin
            if (merge_mask[k]) begin
                if (uc_valid && uc_mask[k])
                    merge_flags[bit_pos(k)] = uc_flags[bit_pos(k)];
                else
                    merge_flags[bit_pos(k)] = alu_flags[bit_pos(k)];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Snapshot of the flags taken after any IDLE-cycle commit has landed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            saved_flags <= 16'd0;
        else if (state == SNAP)
            saved_flags <= flags_cur;
    end

    // Next-state and output decode; requests only pass through in IDLE.
    always_comb begin
        state_nxt    = state;
        alu_ready    = 1'b0;
        uc_ready     = 1'b0;
        update_flags = 9'd0;
        flags_in     = 16'd0;
        saved_valid  = 1'b0;
        int_ack      = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy         = 1'b0;
                alu_ready    = !reset;
                uc_ready     = !reset;
                update_flags = reset ? 9'd0 : merge_mask;
                flags_in     = reset ? 16'd0 : merge_flags;
                if (int_req)
                    state_nxt = SNAP;
            end
            SNAP: begin
                state_nxt = PUSH;
            end
            PUSH: begin
                saved_valid = 1'b1;
                if (saved_ready)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                update_flags = TI_MASK;
                state_nxt    = ACK;
            end
            ACK: begin
                int_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flags_ctrl.sv
// Self-checking bench for flags_ctrl: merge vectors, interrupt
// sequences, reset cases and a randomized run against a reference model.
module tb_flags_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [15:0] alu_flags;
    logic [8:0]  alu_mask;
    logic        alu_ready;
    logic        uc_valid;
    logic [15:0] uc_flags;
    logic [8:0]  uc_mask;
    logic        uc_ready;
    logic        int_req;
    logic        int_ack;
    logic [15:0] flags_cur;
    logic [15:0] saved_flags;
    logic        saved_valid;
    logic        saved_ready;
    logic [15:0] flags_in;
    logic [8:0]  update_flags;
    logic        busy;

    logic        plant_on;
    logic [15:0] drv_flags;
    logic [15:0] plant_reg;

    int checks = 0;
    int errors = 0;

    flags_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_flags    (alu_flags),
        .alu_mask     (alu_mask),
        .alu_ready    (alu_ready),
        .uc_valid     (uc_valid),
        .uc_flags     (uc_flags),
        .uc_mask      (uc_mask),
        .uc_ready     (uc_ready),
        .int_req      (int_req),
        .int_ack      (int_ack),
        .flags_cur    (flags_cur),
        .saved_flags  (saved_flags),
        .saved_valid  (saved_valid),
        .saved_ready  (saved_ready),
        .flags_in     (flags_in),
        .update_flags (update_flags),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] expand(input logic [8:0] m);
        int pos [9] = '{0, 2, 4, 6, 7, 8, 9, 10, 11};
        logic [15:0] r = 16'd0;
        for (int k = 0; k < 9; k++)
            if (m[k]) r[pos[k]] = 1'b1;
        return r;
    endfunction

    // Architectural flags register fed by the DUT write port.
    always @(posedge clk or posedge reset) begin
        if (reset)
            plant_reg <= 16'd0;
        else
            plant_reg <= (plant_reg & ~expand(update_flags))
                       | (flags_in & expand(update_flags));
    end

    assign flags_cur = plant_on ? plant_reg : drv_flags;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_flags = 0; alu_mask = 0;
        uc_valid = 0; uc_flags = 0; uc_mask = 0;
        int_req = 0; saved_ready = 0;
    endtask

    // Reference merge from the flag rules: uc wins where it is valid+masked.
    task automatic ref_merge(output logic [8:0] m, output logic [15:0] f);
        int pos [9] = '{0, 2, 4, 6, 7, 8, 9, 10, 11};
        m = 9'd0;
        f = 16'd0;
        for (int k = 0; k < 9; k++) begin
            if (uc_valid && uc_mask[k]) begin
                m[k] = 1'b1;
                f[pos[k]] = uc_flags[pos[k]];
            end else if (alu_valid && alu_mask[k]) begin
                m[k] = 1'b1;
                f[pos[k]] = alu_flags[pos[k]];
            end
        end
    endtask

    typedef struct {
        logic        av;
        logic [15:0] af;
        logic [8:0]  am;
        logic        uv;
        logic [15:0] uf;
        logic [8:0]  um;
        logic [8:0]  e_upd;
        logic [15:0] e_in;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [8:0]  em;
        logic [15:0] ef;
        int          n_ack;
        int          svc;
        int          bad;
        int          mpos;
        logic [15:0] msaved;
        logic        rst;

        vt[0] = '{1, 16'h0001, 9'h001, 0, 16'h0000, 9'h000, 9'h001, 16'h0001};
        vt[1] = '{1, 16'h0005, 9'h003, 1, 16'h0000, 9'h002, 9'h003, 16'h0001};
        vt[2] = '{0, 16'hFFFF, 9'h1FF, 1, 16'hFFFF, 9'h1FF, 9'h1FF, 16'h0FD5};
        vt[3] = '{1, 16'hFFFF, 9'h000, 1, 16'hFFFF, 9'h000, 9'h000, 16'h0000};
        vt[4] = '{1, 16'hFFFF, 9'h1FF, 0, 16'h0000, 9'h1FF, 9'h1FF, 16'h0FD5};
        vt[5] = '{1, 16'hFFFF, 9'h1FF, 1, 16'h0000, 9'h100, 9'h1FF, 16'h07D5};
        vt[6] = '{1, 16'h0040, 9'h008, 0, 16'h0000, 9'h000, 9'h008, 16'h0040};
        vt[7] = '{1, 16'h0000, 9'h040, 1, 16'h0200, 9'h040, 9'h040, 16'h0200};
        vt[8] = '{0, 16'hFFFF, 9'h1FF, 1, 16'h0400, 9'h080, 9'h080, 16'h0400};

        plant_on = 0;
        drv_flags = 16'h0;
        idle_inputs();
        reset = 1;
        alu_valid = 1; alu_mask = 9'h1FF; alu_flags = 16'hFFFF;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_saved_valid", saved_valid, 0);
        chk("rst_saved_flags", saved_flags, 0);
        chk("rst_int_ack", int_ack, 0);
        chk("rst_update", update_flags, 0);
        tick();
        tick();
        reset = 0;
        idle_inputs();

        // Merge vectors in IDLE
        foreach (vt[i]) begin
            tick();
            alu_valid = vt[i].av; alu_flags = vt[i].af; alu_mask = vt[i].am;
            uc_valid = vt[i].uv; uc_flags = vt[i].uf; uc_mask = vt[i].um;
            #1;
            chk($sformatf("vec%0d_upd", i), update_flags, vt[i].e_upd);
            chk($sformatf("vec%0d_in", i), flags_in, vt[i].e_in);
            chk($sformatf("vec%0d_ardy", i), alu_ready, 1);
            chk($sformatf("vec%0d_urdy", i), uc_ready, 1);
        end

        // Interrupt with no back-pressure
        tick();
        idle_inputs();
        drv_flags = 16'h0302; saved_ready = 1; int_req = 1;
        #1;
        chk("int_accept_busy", busy, 0);
        tick();
        int_req = 0;
        #1;
        chk("snap_busy", busy, 1);
        chk("snap_rdy", alu_ready, 0);
        chk("snap_sv", saved_valid, 0);
        tick();
        #1;
        chk("push_sv", saved_valid, 1);
        chk("push_saved", saved_flags, 16'h0302);
        chk("push_ack", int_ack, 0);
        tick();
        #1;
        chk("clear_upd", update_flags, 9'h060);
        chk("clear_in", flags_in, 0);
        chk("clear_sv", saved_valid, 0);
        tick();
        #1;
        chk("ack_pulse", int_ack, 1);
        chk("ack_upd", update_flags, 0);
        tick();
        #1;
        chk("post_ack", int_ack, 0);
        chk("post_busy", busy, 0);
        chk("post_saved_hold", saved_flags, 16'h0302);

        // Back-pressure: three stalled PUSH cycles
        tick();
        drv_flags = 16'h0ABC; saved_ready = 0; int_req = 1;
        n_ack = -1; svc = 0; bad = 0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            int_req = 0;
            saved_ready = (n == 5);
            alu_valid = 1; alu_mask = 9'h1FF; alu_flags = 16'hFFFF;
            uc_valid = 1; uc_mask = 9'h1FF;
            #1;
            if (int_ack && n_ack < 0) n_ack = n;
            if (saved_valid) svc++;
            if (alu_ready || uc_ready) bad++;
            if (update_flags != 0 && update_flags != 9'h060) bad++;
        end
        chk("bp_ack_latency", n_ack, 7);
        chk("bp_sv_cycles", svc, 4);
        chk("bp_blocked", bad, 0);
        chk("bp_saved", saved_flags, 16'h0ABC);
        tick();
        idle_inputs();
        #1;
        chk("bp_idle", busy, 0);

        // Reset while in PUSH
        tick();
        int_req = 1;
        tick();
        int_req = 0;
        tick();
        chk("rp_push", saved_valid, 1);
        reset = 1;
        #1;
        chk("rp_busy", busy, 0);
        chk("rp_sv", saved_valid, 0);
        tick();
        reset = 0;
        saved_ready = 1;
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            #1;
            if (busy || int_ack || update_flags == 9'h060) bad++;
            tick();
        end
        chk("rp_quiet", bad, 0);

        // Same-cycle ZF update and interrupt accept
        plant_on = 1;
        reset = 1;
        tick();
        reset = 0;
        alu_valid = 1; alu_mask = 9'h008; alu_flags = 16'h0040;
        int_req = 1; saved_ready = 1;
        #1;
        chk("zf_commit", update_flags, 9'h008);
        tick();
        idle_inputs();
        saved_ready = 1;
        tick();
        #1;
        chk("zf_snapshot", saved_flags, 16'h0040);
        tick(); tick(); tick();
        plant_on = 0;

        // Randomized run against the reference model
        mpos = 0;
        msaved = saved_flags;
        for (int c = 0; c < 600; c++) begin
            tick();
            rst = ($urandom_range(0, 32) == 0);
            reset = rst;
            alu_valid = $urandom_range(0, 1)[0];
            alu_flags = 16'($urandom);
            alu_mask = 9'($urandom);
            uc_valid = $urandom_range(0, 1)[0];
            uc_flags = 16'($urandom);
            uc_mask = 9'($urandom);
            int_req = ($urandom_range(0, 3) == 0);
            saved_ready = $urandom_range(0, 1)[0];
            drv_flags = 16'($urandom);
            #1;
            if (rst) begin
                mpos = 0;
                msaved = 16'd0;
            end
            ref_merge(em, ef);
            if (rst || mpos != 0) begin
                em = (!rst && mpos == 3) ? 9'h060 : 9'h000;
                ef = 16'd0;
            end
            chk("r_upd", update_flags, em);
            chk("r_in", flags_in, ef);
            chk("r_rdy", alu_ready, !rst && mpos == 0);
            chk("r_urdy", uc_ready, !rst && mpos == 0);
            chk("r_busy", busy, !rst && mpos != 0);
            chk("r_sv", saved_valid, !rst && mpos == 2);
            chk("r_ack", int_ack, !rst && mpos == 4);
            chk("r_saved", saved_flags, msaved);
            if (!rst) begin
                case (mpos)
                    0: mpos = int_req ? 1 : 0;
                    1: begin msaved = drv_flags; mpos = 2; end
                    2: mpos = saved_ready ? 3 : 2;
                    3: mpos = 4;
                    default: mpos = 0;
                endcase
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flags_ctrl.md
FLAGS_CTRL -- requirements
Module: flags_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  clock.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: alu_valid  input  1 / alu_flags  input  16 / alu_mask  input  9  ALU flag-update request.
REQ-004 SHALL have: alu_ready  output  1  ALU update accepted this cycle when alu_valid=1.
REQ-005 SHALL have: uc_valid  input  1 / uc_flags  input  16 / uc_mask  input  9  microcode flag-update request (POPF, STI, CLI, CLD, ...).
REQ-006 SHALL have: uc_ready  output  1  microcode update accepted this cycle when uc_valid=1.
REQ-007 SHALL have: int_req  input  1  level request for interrupt-entry flag sequence; int_ack  output  1  single-cycle completion pulse.
REQ-008 SHALL have: flags_cur  input  16  current architectural flags from the flags register.
REQ-009 SHALL have: saved_flags  output  16 / saved_valid  output  1 / saved_ready  input  1  snapshot handed to the stack-push path.
REQ-010 SHALL have: flags_in  output  16 / update_flags  output  9  drive the flags register write port.
REQ-011 SHALL have: busy  output  1  high in every state except IDLE.
REQ-012 Mask bit order SHALL be [0..8] = C,P,A,Z,S,T,I,D,O; flag bit indices C0,P2,A4,Z6,S7,T8,I9,D10,O11.

Function
REQ-013 SHALL implement FSM states IDLE, SNAP, PUSH, CLEAR, ACK.
REQ-014 IDLE: alu_ready=uc_ready=1; IDLE->SNAP on int_req=1, else stay.
REQ-015 IDLE merge: update_flags = (alu_valid?alu_mask:0) | (uc_valid?uc_mask:0), combinational, zero latency.
REQ-016 IDLE merge: per mask bit, flags_in takes uc_flags where uc mask bit set and uc_valid, else alu_flags; unmasked flags_in bits SHALL be 0.
REQ-017 Updates accepted in the IDLE cycle that accepts int_req SHALL still issue that cycle (commit before the snapshot).
REQ-018 SNAP: ready outputs 0, update_flags=0; register saved_flags<=flags_cur; ->PUSH next cycle (1 cycle).
REQ-019 PUSH: saved_valid=1, saved_flags stable; ->CLEAR on cycle where saved_ready=1; otherwise hold indefinitely.
REQ-020 CLEAR: update_flags has only T and I bits set (9'b0_0110_0000), flags_in=0; ->ACK next cycle.
REQ-021 ACK: int_ack=1 for exactly this cycle, update_flags=0; ->IDLE next cycle.
REQ-022 In SNAP, PUSH, CLEAR, ACK: alu_ready=uc_ready=0, requests SHALL not be consumed and update_flags carries no ALU/uc bits.
REQ-023 int_req deasserting after acceptance SHALL not abort the sequence; requester drops int_req in cycle after int_ack; int_req still high in IDLE starts a new sequence.
REQ-024 Minimum int_req-accept-to-int_ack latency SHALL be 4 cycles (saved_ready high throughout); each PUSH stall cycle adds 1.
REQ-025 saved_valid SHALL be 0 outside PUSH; saved_flags SHALL hold last snapshot until next SNAP.

Reset
REQ-026 On reset: state=IDLE, saved_flags=0, saved_valid=0, int_ack=0, busy=0, update_flags=0 while reset high.
REQ-027 Reset asserted mid-sequence SHALL return to IDLE immediately with no CLEAR update and no int_ack.

Verification
REQ-028 ALU only: alu_valid=1, mask=9'h001, alu_flags=16'h0001 in IDLE -> update_flags=9'h001, flags_in=16'h0001, alu_ready=1 same cycle.
REQ-029 Collision: alu mask 9'h003 flags 16'h0005, uc mask 9'h002 flags 16'h0000 -> update_flags=9'h003, flags_in=16'h0001.
REQ-030 Interrupt: flags_cur=16'h0302, int_req pulse, saved_ready=1 -> saved_flags=16'h0302 in PUSH, CLEAR mask 9'h060, int_ack 4 cycles after accept.
REQ-031 Back-pressure: saved_ready=0 for 3 PUSH cycles -> saved_valid held 4 cycles, int_ack at accept+7, alu_ready=0 throughout.
REQ-032 Reset in PUSH -> next cycle IDLE, saved_valid=0, no T/I update, no int_ack.
REQ-033 Same-cycle alu_valid (mask 9'h008, ZF=1) and int_req in IDLE -> ZF update issued, snapshot captures Z=1.
